// File: rtl/iic_arbiter.sv
// iic_arbiter: two-client round-robin front end and transaction sequencer for iic_master.
module iic_arbiter #(
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,

    input  logic       req0_i,
    input  logic       rd0_i,
    input  logic [6:0] slv0_i,
    input  logic [7:0] reg0_i,
    input  logic [7:0] dat0_i,
    input  logic       req1_i,
    input  logic       rd1_i,
    input  logic [6:0] slv1_i,
    input  logic [7:0] reg1_i,
    input  logic [7:0] dat1_i,

    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic       done0_o,
    output logic       done1_o,
    output logic       err0_o,
    output logic       err1_o,
    output logic [7:0] rdata_o,
    output logic       busy_o,

    output logic [6:0] m_slv_addr_o,
    output logic [7:0] m_reg_addr_o,
    output logic [7:0] m_data_o,
    output logic       m_wr_o,
    output logic       m_send_o,
    output logic       m_rst_n_o,
    input  logic       m_scl_i,
    input  logic       m_sda_i,
    input  logic [7:0] m_rdata_i
);

    localparam int unsigned SLV_W  = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

    typedef struct packed {
        logic              rd;
        logic [SLV_W-1:0]  slv;
        logic [BYTE_W-1:0] reg_a;
        logic [BYTE_W-1:0] dat;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_STOP,
        S_DONE,
        S_ABORT
    } state_t;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    cmd_t              cmd0, cmd1;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [BYTE_W-1:0] rdata_q, rdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              send_q, send_d;
    logic              busy_q, busy_d;
    logic              mrst_n_q, mrst_n_d;
    logic              scl_q, sda_q;
    logic              win, req_other, load, load_sel;
    logic              start_c, stop_c, timeout_c;

    assign cmd0 = {rd0_i, slv0_i, reg0_i, dat0_i};
    assign cmd1 = {rd1_i, slv1_i, reg1_i, dat1_i};

    // Round-robin pick: on a tie the client not served last wins.
    assign win       = (req0_i & req1_i) ? ~last_q : req1_i;
    assign req_other = owner_q ? req0_i : req1_i;

    // Bus condition detection; scl_q must be high so a simultaneous SCL/SDA rise is not a STOP.
    assign start_c   = m_scl_i & scl_q & ~m_sda_i &  sda_q;
    assign stop_c    = m_scl_i & scl_q &  m_sda_i & ~sda_q;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_c = (cnt_q >= TO_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        send_d   = 1'b0;
        done_d   = 2'b00;
        err_d    = 2'b00;
        gnt_d    = 2'b00;
        load     = 1'b0;
        load_sel = win;

        case (state_q)
            S_IDLE: begin
                if (req0_i | req1_i) begin
                    load     = 1'b1;
                    load_sel = win;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                send_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                cnt_d = cnt_inc;
                if (start_c) begin
                    state_d = S_WAIT_STOP;
                end else if (timeout_c) begin
                    state_d        = S_ABORT;
                    err_d[owner_q] = 1'b1;
                    last_d         = owner_q;
                    cnt_d          = '0;
                end
            end
            S_WAIT_STOP: begin
                cnt_d = cnt_inc;
                if (stop_c) begin
                    state_d         = S_DONE;
                    done_d[owner_q] = 1'b1;
                    // Master clears its read byte right after STOP, so take the live value.
                    if (cmd_q.rd) begin
                        rdata_d = m_rdata_i;
                    end
                end else if (timeout_c) begin
                    state_d        = S_ABORT;
                    err_d[owner_q] = 1'b1;
                    last_d         = owner_q;
                    cnt_d          = '0;
                end
            end
            S_DONE: begin
                last_d = owner_q;
                // Hand straight over to a waiting other client; the finished one re-arbitrates from IDLE.
                if (req_other) begin
                    load     = 1'b1;
                    load_sel = ~owner_q;
                    state_d  = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                cnt_d = cnt_inc;
                if (cnt_q >= RST_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            owner_d = load_sel;
            cmd_d   = load_sel ? cmd1 : cmd0;
        end

        if (state_d != S_IDLE) begin
            gnt_d[owner_d] = 1'b1;
        end
        busy_d   = (state_d != S_IDLE);
        mrst_n_d = (state_d != S_ABORT);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            rdata_q  <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            send_q   <= 1'b0;
            busy_q   <= 1'b0;
            mrst_n_q <= 1'b0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            send_q   <= send_d;
            busy_q   <= busy_d;
            mrst_n_q <= mrst_n_d;
            scl_q    <= m_scl_i;
            sda_q    <= m_sda_i;
        end
    end

    assign gnt0_o       = gnt_q[0];
    assign gnt1_o       = gnt_q[1];
    assign done0_o      = done_q[0];
    assign done1_o      = done_q[1];
    assign err0_o       = err_q[0];
    assign err1_o       = err_q[1];
    assign rdata_o      = rdata_q;
    assign busy_o       = busy_q;
    assign m_slv_addr_o = cmd_q.slv;
    assign m_reg_addr_o = cmd_q.reg_a;
    assign m_data_o     = cmd_q.dat;
    assign m_wr_o       = cmd_q.rd;
    assign m_send_o     = send_q;
    assign m_rst_n_o    = mrst_n_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// tb_iic_arbiter: scoreboard bench with a bus-event agent standing in for iic_master.
`timescale 1ns/1ps
module tb_iic_arbiter;

    localparam int unsigned TO = 64;
    localparam int unsigned RC = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       req0_i = 1'b0, rd0_i = 1'b0, req1_i = 1'b0, rd1_i = 1'b0;
    logic [6:0] slv0_i = '0, slv1_i = '0;
    logic [7:0] reg0_i = '0, reg1_i = '0, dat0_i = '0, dat1_i = '0;
    logic       gnt0_o, gnt1_o, done0_o, done1_o, err0_o, err1_o, busy_o;
    logic [7:0] rdata_o, m_reg_addr_o, m_data_o;
    logic [6:0] m_slv_addr_o;
    logic       m_wr_o, m_send_o, m_rst_n_o;
    logic       m_scl_i = 1'b1, m_sda_i = 1'b1;
    logic [7:0] m_rdata_i = '0;

    // mode: 0 = normal transaction, 1 = bus stays idle (timeout), 2 = reset issued mid-transaction
    typedef struct {
        int       client;
        bit       rd;
        bit [6:0] slv;
        bit [7:0] rg;
        bit [7:0] dat;
        int       mode;
        bit [7:0] rbyte;
    } scen_t;

    typedef struct {
        int       client;
        bit       err;
        bit [7:0] rdata;
    } exp_t;

    scen_t    scen_q[$];
    exp_t     exp_q[$];
    int       cyc_q[$];
    scen_t    cfg[2];
    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    int       last_m = 1;
    bit [7:0] rdata_m = 8'h00;

    iic_arbiter #(.TIMEOUT(TO), .RST_CYCLES(RC)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_i(req0_i), .rd0_i(rd0_i), .slv0_i(slv0_i), .reg0_i(reg0_i), .dat0_i(dat0_i),
        .req1_i(req1_i), .rd1_i(rd1_i), .slv1_i(slv1_i), .reg1_i(reg1_i), .dat1_i(dat1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .done0_o(done0_o), .done1_o(done1_o),
        .err0_o(err0_o), .err1_o(err1_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .m_slv_addr_o(m_slv_addr_o), .m_reg_addr_o(m_reg_addr_o), .m_data_o(m_data_o),
        .m_wr_o(m_wr_o), .m_send_o(m_send_o), .m_rst_n_o(m_rst_n_o),
        .m_scl_i(m_scl_i), .m_sda_i(m_sda_i), .m_rdata_i(m_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_reset();
        check("rst_gnt0", gnt0_o, 0);
        check("rst_gnt1", gnt1_o, 0);
        check("rst_done", {done1_o, done0_o}, 0);
        check("rst_err", {err1_o, err0_o}, 0);
        check("rst_busy", busy_o, 0);
        check("rst_send", m_send_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_m_slv", m_slv_addr_o, 0);
        check("rst_m_reg", m_reg_addr_o, 0);
        check("rst_m_dat", m_data_o, 0);
        check("rst_m_wr", m_wr_o, 0);
        check("rst_m_rst_n", m_rst_n_o, 0);
    endtask

    task automatic step(input logic scl, input logic sda);
        m_scl_i = scl;
        m_sda_i = sda;
        @(posedge clk);
        #1;
    endtask

    task automatic data_bits();
        bit b;
        for (int i = 0; i < 9; i++) begin
            b = 1'($urandom_range(0, 1));
            step(1'b0, b);
            step(1'b1, b);
        end
    endtask

    // Reference model: decide service order from the round-robin rule, queue scenarios and expectations, drive requests.
    task automatic run_round(input bit u0, input bit u1);
        int order[$];
        int n;
        if (u0 && u1) begin
            order.push_back(1 - last_m);
            order.push_back(last_m);
        end else if (u0) begin
            order.push_back(0);
        end else begin
            order.push_back(1);
        end
        foreach (order[i]) begin
            scen_t s;
            exp_t  e;
            s = cfg[order[i]];
            s.client = order[i];
            scen_q.push_back(s);
            if (s.mode == 0 && s.rd) rdata_m = s.rbyte;
            e.client = s.client;
            e.err    = (s.mode == 1);
            e.rdata  = rdata_m;
            exp_q.push_back(e);
            last_m = s.client;
        end
        rd0_i = cfg[0].rd; slv0_i = cfg[0].slv; reg0_i = cfg[0].rg; dat0_i = cfg[0].dat;
        rd1_i = cfg[1].rd; slv1_i = cfg[1].slv; reg1_i = cfg[1].rg; dat1_i = cfg[1].dat;
        req0_i = u0;
        req1_i = u1;
        n = 0;
        while ((req0_i || req1_i) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (done0_o || err0_o) req0_i = 1'b0;
            if (done1_o || err1_o) req1_i = 1'b0;
        end
        if (req0_i || req1_i) begin
            total++;
            bad++;
            $display("FAIL round_timeout got=pending want=complete (cycle %0d)", cyc);
            req0_i = 1'b0;
            req1_i = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int c, input bit rd, input bit [6:0] slv, input bit [7:0] rg,
                           input bit [7:0] dat, input int mode, input bit [7:0] rbyte);
        cfg[c].client = c;
        cfg[c].rd     = rd;
        cfg[c].slv    = slv;
        cfg[c].rg     = rg;
        cfg[c].dat    = dat;
        cfg[c].mode   = mode;
        cfg[c].rbyte  = rbyte;
    endtask

    // Bus agent: reacts to each send pulse with the queued bus scenario.
    always begin : agent
        scen_t s;
        @(posedge clk);
        #1;
        if (m_send_o) begin
            if (scen_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_send got=send want=none (cycle %0d)", cyc);
            end else begin
                s = scen_q.pop_front();
                check("send_gnt0", gnt0_o, s.client == 0);
                check("send_gnt1", gnt1_o, s.client == 1);
                check("send_m_slv", m_slv_addr_o, s.slv);
                check("send_m_reg", m_reg_addr_o, s.rg);
                check("send_m_dat", m_data_o, s.dat);
                check("send_m_wr", m_wr_o, s.rd);
                if (s.mode == 1) begin
                    m_scl_i = 1'b1;
                    m_sda_i = 1'b1;
                    cyc_q.push_back(cyc + TO);
                    repeat (TO) begin
                        @(posedge clk);
                        #1;
                    end
                    for (int j = 0; j <= RC; j++) begin
                        check("abort_m_rst_n", m_rst_n_o, j == RC);
                        if (j < RC) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end else if (s.mode == 2) begin
                    step(1, 1); step(1, 1); step(1, 0); step(1, 0);
                    repeat (30) step(0, 0);
                    m_scl_i = 1'b1;
                    m_sda_i = 1'b1;
                end else begin
                    m_rdata_i = ~s.rbyte;
                    step(1, 1); step(1, 1); step(1, 0); step(1, 0);
                    data_bits();
                    if (s.rd) begin
                        // Repeated START: SCL and SDA rise together first, which must not look like a STOP.
                        step(0, 0); step(1, 1); step(1, 1); step(1, 0); step(1, 0);
                        data_bits();
                    end
                    step(0, 0); step(1, 0); step(1, 0);
                    m_rdata_i = s.rbyte;
                    m_scl_i   = 1'b1;
                    m_sda_i   = 1'b1;
                    cyc_q.push_back(cyc + 1);
                    @(posedge clk);
                    #1;
                    m_rdata_i = 8'h00;
                end
            end
        end
    end

    // Monitor: compare every done/err pulse against the scoreboard.
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (!rst_i && (done0_o || done1_o || err0_o || err1_o)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion got=%b want=none (cycle %0d)",
                         {err1_o, err0_o, done1_o, done0_o}, cyc);
            end else begin
                e = exp_q.pop_front();
                check("done0", done0_o, e.client == 0 && !e.err);
                check("done1", done1_o, e.client == 1 && !e.err);
                check("err0", err0_o, e.client == 0 && e.err);
                check("err1", err1_o, e.client == 1 && e.err);
                check("rdata", rdata_o, e.rdata);
                if (cyc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL completion_cycle got=%0d want=none (cycle %0d)", cyc, cyc);
                end else begin
                    check("completion_cycle", cyc, cyc_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int u;
        scen_t s;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check("m_rst_n_release", m_rst_n_o, 1);

        // Directed write, then directed read.
        set_cfg(0, 0, 7'h50, 8'h12, 8'h3C, 0, 8'h77);
        run_round(1, 0);
        set_cfg(1, 1, 7'h50, 8'h34, 8'h00, 0, 8'hA5);
        run_round(0, 1);
        check("rdata_held", rdata_o, 8'hA5);

        // Contention: alternating service while both are held.
        set_cfg(0, 0, 7'h11, 8'h01, 8'h5A, 0, 8'h00);
        set_cfg(1, 1, 7'h22, 8'h02, 8'h00, 0, 8'h3C);
        repeat (3) run_round(1, 1);

        // Timeout on client 0.
        set_cfg(0, 0, 7'h33, 8'h03, 8'h99, 1, 8'h00);
        run_round(1, 0);

        // Reset while waiting for STOP on a read.
        set_cfg(1, 1, 7'h44, 8'h04, 8'h00, 2, 8'hEE);
        s = cfg[1];
        scen_q.push_back(s);
        rd1_i = s.rd; slv1_i = s.slv; reg1_i = s.rg; dat1_i = s.dat;
        req1_i = 1'b1;
        n = 0;
        while (!m_send_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_reset_send_seen", m_send_o, 1);
        repeat (15) @(posedge clk);
        #1;
        check("mid_reset_busy", busy_o, 1);
        rst_i  = 1'b1;
        req1_i = 1'b0;
        @(posedge clk);
        #1;
        check_reset();
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_m_rst_n", m_rst_n_o, 1);
        check("mid_reset_idle", busy_o, 0);
        last_m  = 1;
        rdata_m = 8'h00;
        repeat (40) @(posedge clk);
        #1;
        set_cfg(1, 1, 7'h44, 8'h05, 8'h00, 0, 8'h6B);
        run_round(0, 1);

        // Randomized rounds.
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 2; c++) begin
                set_cfg(c, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                        ($urandom_range(0, 9) == 0) ? 1 : 0, 8'($urandom));
            end
            u = $urandom_range(1, 3);
            run_round(u[0], u[1]);
        end

        repeat (10) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("scen_q_drained", scen_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
